mem_slave: RTL and testbench

//  Memory target sitting behind the memory interface bundle; it terminates the valid/ready

---
 rtl/mem_slave.sv | 133 +++++++++++++
 tb/tb_mem_slave.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_slave.sv
// mem_slave: single-port word memory behind a valid/ready request channel.
// Reads and writes share the channel; LATENCY busy cycles emulate a slow
// memory. With LATENCY=0 the target accepts one request every cycle.
module mem_slave #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter start value: BUSY lasts cnt+1 edges, so LATENCY-1 gives exactly
  // LATENCY cycles with ready low.
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;

  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  accept;
  logic                  mem_we;

  // A request is taken only when the target advertised ready before the edge.
  assign accept = valid_i && ready_q;
  assign mem_we = accept && wr_en_i;

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

  // Memory array: cleared by reset so reads after reset return zero; the
  // write lands on the accept edge, so a read accepted next cycle sees it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Next-state logic for the IDLE/BUSY handshake FSM and the read result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (!ready_q) begin
          // First edge after reset release: open the channel.
          ready_d = 1'b1;
        end else if (valid_i) begin
          addr_d = addr_i;
          wr_d   = wr_en_i;
          if (LATENCY == 0) begin
            // Zero-latency: reads complete on the accept edge itself.
            if (!wr_en_i) begin
              rdata_d = mem_q[addr_i];
            end
          end else begin
            ready_d = 1'b0;
            cnt_d   = LAT_M1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // Channel inputs are ignored here; only the captured request matters.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          if (!wr_q) begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // Command fields must be known whenever a request is presented.
  a_no_x_cmd: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i |-> !$isunknown({wr_en_i, addr_i}));

  // Count accepted transactions.
  c_accept: cover property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i && ready_q);

endmodule

// File: tb/tb_mem_slave.sv
// Bench for mem_slave: two instances (LATENCY 0 and 2) driven by directed
// scenarios then random traffic, checked every cycle against a timestamp model.
module tb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_s   [2];
  logic        we_s  [2];
  logic [3:0]  a_s   [2];
  logic [15:0] d_s   [2];
  logic        rdy_s [2];
  logic [15:0] rd_s  [2];

  always #5 clk = ~clk;

  mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .LATENCY(0)) u_lat0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_s[0]), .wr_en_i(we_s[0]),
    .addr_i(a_s[0]), .wdata_i(d_s[0]), .ready_o(rdy_s[0]), .rdata_o(rd_s[0])
  );

  mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_s[1]), .wr_en_i(we_s[1]),
    .addr_i(a_s[1]), .wdata_i(d_s[1]), .ready_o(rdy_s[1]), .rdata_o(rd_s[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction accepted at edge e with latency L completes at edge e+L.
  int          lat [2] = '{0, 2};
  logic [15:0] m_mem   [2][16];
  logic        m_ready [2];
  logic        m_busy  [2];
  logic        m_pwr   [2];
  logic [3:0]  m_pa    [2];
  logic [15:0] m_rdata [2];
  int          m_done  [2];
  int          m_acc   [2] = '{0, 0};
  int          dut_acc [2] = '{0, 0};
  int          edge_no = 0;

  always @(posedge clk) begin
    edge_no++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_mem[k][i] = 16'h0;
        m_ready[k] = 1'b0;
        m_busy[k]  = 1'b0;
        m_rdata[k] = 16'h0;
      end else if (m_busy[k]) begin
        if (edge_no == m_done[k]) begin
          m_busy[k]  = 1'b0;
          m_ready[k] = 1'b1;
          if (!m_pwr[k]) m_rdata[k] = m_mem[k][m_pa[k]];
        end
      end else if (!m_ready[k]) begin
        m_ready[k] = 1'b1;
      end else if (v_s[k]) begin
        m_acc[k]++;
        if (we_s[k]) m_mem[k][a_s[k]] = d_s[k];
        else if (lat[k] == 0) m_rdata[k] = m_mem[k][a_s[k]];
        if (lat[k] > 0) begin
          m_ready[k] = 1'b0;
          m_busy[k]  = 1'b1;
          m_pwr[k]   = we_s[k];
          m_pa[k]    = a_s[k];
          m_done[k]  = edge_no + lat[k];
        end
      end
    end
  end

  // Per-cycle comparison, midway between active edges.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("rst_ready[%0d]", k), 32'(rdy_s[k]), 32'd0);
        check($sformatf("rst_rdata[%0d]", k), 32'(rd_s[k]), 32'd0);
      end else begin
        check($sformatf("ready[%0d]", k), 32'(rdy_s[k]), 32'(m_ready[k]));
        check($sformatf("rdata[%0d]", k), 32'(rd_s[k]), 32'(m_rdata[k]));
        if (v_s[k] && rdy_s[k]) dut_acc[k]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic we,
                       input logic [3:0] a, input logic [15:0] d);
    v_s[k] = v; we_s[k] = we; a_s[k] = a; d_s[k] = d;
  endtask

  // Present a request and return 1 time unit after the edge that accepts it.
  task automatic send(input int k, input logic we, input logic [3:0] a, input logic [15:0] d);
    logic got;
    logic r;
    got = 1'b0;
    drive(k, 1'b1, we, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      r = rdy_s[k];
      tick();
      if (r) got = 1'b1;
    end
    v_s[k] = 1'b0;
    check($sformatf("send_accepted[%0d]", k), 32'(got), 32'd1);
  endtask

  task automatic wait_ready(input int k);
    for (int i = 0; i < 40 && !rdy_s[k]; i++) tick();
    check($sformatf("wait_ready[%0d]", k), 32'(rdy_s[k]), 32'd1);
  endtask

  int base_dut;
  int base_mod;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 4'h0, 16'h0);

    // 1: reset held 3 cycles, ready rises one edge after release
    repeat (3) tick();
    check("t1_ready_in_rst", 32'(rdy_s[1]), 32'd0);
    rst_n = 1'b1;
    check("t1_ready_before_edge", 32'(rdy_s[0]), 32'd0);
    tick();
    check("t1_ready0_up", 32'(rdy_s[0]), 32'd1);
    check("t1_ready2_up", 32'(rdy_s[1]), 32'd1);
    check("t1_rdata", 32'(rd_s[1]), 32'd0);

    // 2: zero latency write then read next cycle
    send(0, 1'b1, 4'd3, 16'hA5A5);
    check("t2_ready_after_wr", 32'(rdy_s[0]), 32'd1);
    send(0, 1'b0, 4'd3, 16'h0);
    check("t2_rdata", 32'(rd_s[0]), 32'hA5A5);
    check("t2_ready_after_rd", 32'(rdy_s[0]), 32'd1);

    // 3: latency 2 read; address change during BUSY ignored
    send(1, 1'b1, 4'd3, 16'hA5A5);
    wait_ready(1);
    drive(1, 1'b1, 1'b0, 4'd3, 16'h0);
    tick();
    drive(1, 1'b0, 1'b1, 4'd5, 16'hDEAD);
    check("t3_ready_T0", 32'(rdy_s[1]), 32'd0);
    check("t3_rdata_T0", 32'(rd_s[1]), 32'd0);
    tick();
    check("t3_ready_T1", 32'(rdy_s[1]), 32'd0);
    check("t3_rdata_T1", 32'(rd_s[1]), 32'd0);
    tick();
    check("t3_ready_T2", 32'(rdy_s[1]), 32'd1);
    check("t3_rdata_T2", 32'(rd_s[1]), 32'hA5A5);

    // 4: valid held 6 cycles -> 2 accepts
    base_dut = dut_acc[1];
    base_mod = m_acc[1];
    drive(1, 1'b1, 1'b0, 4'd7, 16'h0);
    repeat (6) tick();
    drive(1, 1'b0, 1'b0, 4'd7, 16'h0);
    check("t4_dut_accepts", 32'(dut_acc[1] - base_dut), 32'd2);
    check("t4_model_accepts", 32'(m_acc[1] - base_mod), 32'd2);

    // 5: reset during a BUSY write clears the array
    wait_ready(1);
    send(1, 1'b1, 4'd15, 16'h1234);
    check("t5_busy", 32'(rdy_s[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_async_rdata", 32'(rd_s[1]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_ready(1);
    send(1, 1'b0, 4'd15, 16'h0);
    wait_ready(1);
    check("t5_rdata", 32'(rd_s[1]), 32'h0000);

    // 6: never-written address, then write/read back, then other address
    send(0, 1'b0, 4'd0, 16'h0);
    check("t6_rd0_fresh", 32'(rd_s[0]), 32'h0);
    send(0, 1'b1, 4'd0, 16'hFFFF);
    send(0, 1'b0, 4'd0, 16'h0);
    check("t6_rd0", 32'(rd_s[0]), 32'hFFFF);
    send(0, 1'b0, 4'd15, 16'h0);
    check("t6_rd15", 32'(rd_s[0]), 32'h0);

    // Random traffic on both instances, with one reset pulse
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 16'($urandom));
      end
      if (c == 400) rst_n = 1'b0;
      if (c == 403) rst_n = 1'b1;
      tick();
    end
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 4'h0, 16'h0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
